rggen_register_bus_initiator: RTL
=================================

Name: rggen_register_bus_initiator

Overview:
- Initiator (host) end of the register-bus interface that register blocks respond on.
- Accepts one command at a time on a valid/ready request port and drives valid/access/address/write_data/strobe to the register array.
- Collects ready/status/read_data from the registers, synthesizes DECERR when no register is active, and SLVERR when the timeout expires.
- Returns one buffered response per command on a valid/ready response port; used in bus adapters, debug hosts and self-test sequencers.

Parameters:
- ADDRESS_WIDTH, 8, register-bus address width
- BUS_WIDTH, 32, data width; strobe is a per-bit mask of the same width
- TIMEOUT_CYCLES, 0, 0 disables the timeout; N>0 aborts after N bus cycles with no ready
- TIMEOUT_WIDTH, 8, counter width; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_WIDTH

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_command_valid  in  1  command present
- o_command_ready  out  1  command accepted this cycle
- i_command_access  in  2  2'b10 read, 2'b11 write, 2'b01 posted write
- i_command_address  in  ADDRESS_WIDTH  byte address
- i_command_write_data  in  BUS_WIDTH  write data
- i_command_strobe  in  BUS_WIDTH  bit mask
- o_register_valid  out  1  bus request
- o_register_access  out  2  registered copy of command access
- o_register_address  out  ADDRESS_WIDTH  registered address
- o_register_write_data  out  BUS_WIDTH  registered write data
- o_register_strobe  out  BUS_WIDTH  registered strobe
- i_register_active  in  1  OR of all register active flags
- i_register_ready  in  1  OR of all register ready flags
- i_register_status  in  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
- i_register_read_data  in  BUS_WIDTH  OR of all register read data
- o_response_valid  out  1  response present
- i_response_ready  in  1  response consumed
- o_response_status  out  2  final status
- o_response_read_data  out  BUS_WIDTH  read data; zero for writes and errors

Behaviour:
- FSM states: IDLE, BUS, RESPONSE. Reset (i_rst=1 at a clock edge) forces IDLE; all outputs 0; timeout counter 0.
- IDLE: o_command_ready=1. When i_command_valid=1, register access/address/write_data/strobe, assert o_register_valid on the next cycle, and go to BUS. o_command_ready is 0 in BUS and RESPONSE, so at most one command is outstanding.
- BUS: o_register_valid=1; the bus fields stay stable until completion. Completion is decided each cycle, highest priority first:
  a) i_register_active=0: DECERR, read_data=0.
  b) i_register_ready=1: status = i_register_status; read_data = i_register_read_data for reads, 0 for writes and posted writes.
  c) TIMEOUT_CYCLES>0 and counter == TIMEOUT_CYCLES-1: SLVERR, read_data=0.
- On completion in BUS: capture the status/data into the response registers, drop o_register_valid on the next cycle, set o_response_valid=1, and go to RESPONSE. Minimum command-accept to response-valid latency is 2 cycles (accept edge, then a 1-cycle bus phase).
- Timeout counter: clears on command accept; increments in BUS each cycle without completion; saturates and does not wrap.
- Error responses are forced regardless of the incoming bus status; an incoming ready in the same cycle as the timeout wins over the timeout.
- RESPONSE: o_response_valid=1 with status and data held stable. When i_response_ready=1, clear o_response_valid and return to IDLE. o_command_ready rises in the cycle after the handshake, so there is no command/response bypass.
- Reset mid-transaction: the bus request and any pending response are dropped immediately at the reset edge; no response is ever issued for the aborted command.
- Read data from registers is not sampled outside BUS.
- Unsupported access code 2'b00: the block does not drive the bus; it returns SLVERR after 1 cycle through RESPONSE.

Decomposition:
- Shared package/header constants: access codes (RGGEN_READ, RGGEN_WRITE, RGGEN_POSTED_WRITE) and status codes (OKAY, EXOKAY, SLVERR, DECERR), shared with the responder-side register modules.
- Natural sub-module: rggen_initiator_timeout, the saturating counter plus expiry compare, tied off when TIMEOUT_CYCLES=0.
- FSM and response registers stay in the top module.

Test Plan:
- Write 0x12345678, strobe 0xFFFFFFFF, to address 0x04; responder asserts active, then ready on the 3rd bus cycle with 00 -> register bus held stable 3 cycles; response OKAY, read_data 0.
- Read 0x08; responder returns ready, status 00, data 0xCAFEF00D on the 1st bus cycle -> response valid 2 cycles after accept with data 0xCAFEF00D.
- Read 0x3C with i_register_active=0 -> DECERR, data 0, after a 1-cycle bus phase.
- TIMEOUT_CYCLES=4; active=1, ready never asserted -> SLVERR after exactly 4 bus cycles; o_register_valid drops; repeat with ready arriving on cycle 4 -> responder status wins.
- Hold i_response_ready=0 for 5 cycles with a second command pending -> response stable, o_command_ready=0; the second command is accepted 1 cycle after the handshake.
- Assert i_rst during BUS, then during RESPONSE -> all outputs 0 next cycle; FSM IDLE; no stale response after reset release.

Source files
------------

// File: rtl/rggen_register_bus_initiator_pkg.sv
// rtl/rggen_register_bus_initiator_pkg.sv - register-bus access/status codes and initiator state type
package rggen_register_bus_initiator_pkg;

    localparam logic [1:0] RGGEN_READ         = 2'b10;
    localparam logic [1:0] RGGEN_WRITE        = 2'b11;
    localparam logic [1:0] RGGEN_POSTED_WRITE = 2'b01;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESPONSE
    } initiator_state_e;

    // Access code 2'b00 is reserved; it never reaches the register bus.
    function automatic logic is_supported_access(input logic [1:0] access);
        return access != 2'b00;
    endfunction

endpackage

// File: rtl/rggen_initiator_timeout.sv
// rtl/rggen_initiator_timeout.sv - saturating bus-phase counter with expiry compare
module rggen_initiator_timeout #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam bit ENABLED = TIMEOUT_CYCLES > 0;
    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT =
        TIMEOUT_WIDTH'(ENABLED ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TIMEOUT_WIDTH-1:0] MAX_COUNT = '1;

    logic [TIMEOUT_WIDTH-1:0] count;

    // With the timeout disabled the counter never leaves zero and the compare is masked off.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count <= '0;
        end else if (ENABLED && i_count && (count != MAX_COUNT)) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

    assign o_expired = ENABLED && (count == LIMIT);

endmodule

// File: rtl/rggen_register_bus_initiator.sv
// rtl/rggen_register_bus_initiator.sv - single-outstanding register-bus initiator with buffered response
module rggen_register_bus_initiator
    import rggen_register_bus_initiator_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_command_valid,
    output logic                     o_command_ready,
    input  logic [1:0]               i_command_access,
    input  logic [ADDRESS_WIDTH-1:0] i_command_address,
    input  logic [BUS_WIDTH-1:0]     i_command_write_data,
    input  logic [BUS_WIDTH-1:0]     i_command_strobe,
    output logic                     o_register_valid,
    output logic [1:0]               o_register_access,
    output logic [ADDRESS_WIDTH-1:0] o_register_address,
    output logic [BUS_WIDTH-1:0]     o_register_write_data,
    output logic [BUS_WIDTH-1:0]     o_register_strobe,
    input  logic                     i_register_active,
    input  logic                     i_register_ready,
    input  logic [1:0]               i_register_status,
    input  logic [BUS_WIDTH-1:0]     i_register_read_data,
    output logic                     o_response_valid,
    input  logic                     i_response_ready,
    output logic [1:0]               o_response_status,
    output logic [BUS_WIDTH-1:0]     o_response_read_data
);

    initiator_state_e     state;
    logic                 accept;
    logic                 complete;
    logic                 expired;
    logic [1:0]           bus_status;
    logic [BUS_WIDTH-1:0] bus_read_data;

    assign accept = (state == IDLE) && o_command_ready && i_command_valid;

    // Completion priority: no active register, then responder ready, then timeout.
    always_comb begin
        complete      = 1'b0;
        bus_status    = OKAY;
        bus_read_data = '0;
        if (state == BUS) begin
            if (!i_register_active) begin
                complete   = 1'b1;
                bus_status = DECERR;
            end else if (i_register_ready) begin
                complete   = 1'b1;
                bus_status = i_register_status;
                if (o_register_access == RGGEN_READ) begin
                    bus_read_data = i_register_read_data;
                end
            end else if (expired) begin
                complete   = 1'b1;
                bus_status = SLVERR;
            end
        end
    end

    rggen_initiator_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (accept),
        .i_count   ((state == BUS) && !complete),
        .o_expired (expired)
    );

    // Command ready is registered so it reads 0 in the cycle following reset or acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= IDLE;
            o_command_ready       <= 1'b0;
            o_register_valid      <= 1'b0;
            o_register_access     <= '0;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
            o_response_valid      <= 1'b0;
            o_response_status     <= '0;
            o_response_read_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_command_ready <= 1'b0;
                        if (is_supported_access(i_command_access)) begin
                            o_register_valid      <= 1'b1;
                            o_register_access     <= i_command_access;
                            o_register_address    <= i_command_address;
                            o_register_write_data <= i_command_write_data;
                            o_register_strobe     <= i_command_strobe;
                            state                 <= BUS;
                        end else begin
                            o_response_valid     <= 1'b1;
                            o_response_status    <= SLVERR;
                            o_response_read_data <= '0;
                            state                <= RESPONSE;
                        end
                    end else begin
                        o_command_ready <= 1'b1;
                    end
                end
                BUS: begin
                    if (complete) begin
                        o_register_valid     <= 1'b0;
                        o_response_valid     <= 1'b1;
                        o_response_status    <= bus_status;
                        o_response_read_data <= bus_read_data;
                        state                <= RESPONSE;
                    end
                end
                RESPONSE: begin
                    if (i_response_ready) begin
                        o_response_valid <= 1'b0;
                        o_command_ready  <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
